// File: rtl/bitonic_sort_sequencer.sv
// Loads N words, sorts them in place with a bitonic network evaluated one
// compare-exchange per clock, then streams them out in non-increasing order.
module bitonic_sort_sequencer #(
  parameter int LOG_N         = 3,
  parameter int NETWORK_WIDTH = 8,
  parameter int INDEX_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NETWORK_WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NETWORK_WIDTH-1:0] out_data,
  output logic [INDEX_WIDTH-1:0]   out_index,
  output logic                     busy,
  output logic                     done
);

  localparam int N  = 1 << LOG_N;
  localparam int KW = $clog2(LOG_N + 1);
  localparam logic [LOG_N-1:0] PTR_LAST = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] P_LAST   = LOG_N'(N / 2 - 1);
  localparam logic [KW-1:0]    K_LAST   = KW'(LOG_N - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [LOG_N-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LOG_N-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LOG_N-1:0]         p_q, p_d;
  // k_q holds k_log-1 so that every counter rests at zero outside SORT
  logic [KW-1:0]            k_q, k_d;
  logic [KW-1:0]            j_q, j_d;
  logic [NETWORK_WIDTH-1:0] value_q [N];
  logic [NETWORK_WIDTH-1:0] value_d [N];
  logic [INDEX_WIDTH-1:0]   index_q [N];
  logic [INDEX_WIDTH-1:0]   index_d [N];

  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [NETWORK_WIDTH-1:0] out_data_q, out_data_d;
  logic [INDEX_WIDTH-1:0]   out_index_q, out_index_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [LOG_N-1:0] lo_mask_s;
  logic [LOG_N-1:0] i_s;
  logic [LOG_N-1:0] l_s;
  logic [LOG_N:0]   i_ext_s;
  logic             asc_s;
  logic             swap_s;

  // Pair decode: insert a zero at bit j_log of p, partner differs only in that bit
  always_comb begin
    lo_mask_s = (LOG_N'(1) << j_q) - LOG_N'(1);
    i_s       = ((p_q & ~lo_mask_s) << 1) | (p_q & lo_mask_s);
    l_s       = i_s | (LOG_N'(1) << j_q);
    i_ext_s   = {1'b0, i_s};
    asc_s     = i_ext_s[k_q + KW'(1)];
    if (asc_s) begin
      swap_s = (value_q[i_s] > value_q[l_s]);
    end else begin
      swap_s = (value_q[i_s] < value_q[l_s]);
    end
  end

  // Next-state, bank update and registered-output precompute
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    p_d      = p_q;
    k_d      = k_q;
    j_d      = j_q;
    value_d  = value_q;
    index_d  = index_q;
    done_d   = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          value_d[wr_ptr_q] = in_data;
          index_d[wr_ptr_q] = INDEX_WIDTH'(wr_ptr_q);
          wr_ptr_d          = wr_ptr_q + LOG_N'(1);
          if (wr_ptr_q == PTR_LAST) begin
            state_d = ST_SORT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SORT: begin
        if (swap_s) begin
          value_d[i_s] = value_q[l_s];
          value_d[l_s] = value_q[i_s];
          index_d[i_s] = index_q[l_s];
          index_d[l_s] = index_q[i_s];
        end else begin
          value_d = value_q;
        end
        if (p_q == P_LAST) begin
          p_d = '0;
          if (j_q == '0) begin
            if (k_q == K_LAST) begin
              k_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              k_d = k_q + KW'(1);
              j_d = k_q + KW'(1);
            end
          end else begin
            j_d = j_q - KW'(1);
          end
        end else begin
          p_d = p_q + LOG_N'(1);
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + LOG_N'(1);
          if (rd_ptr_q == PTR_LAST) begin
            state_d = ST_LOAD;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    in_ready_d  = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_LOAD);
    out_valid_d = (state_d == ST_DRAIN);
    if (out_valid_d) begin
      out_data_d  = value_d[rd_ptr_d];
      out_index_d = index_d[rd_ptr_d];
    end else begin
      out_data_d  = '0;
      out_index_d = '0;
    end
  end

  // State, bank and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      p_q         <= '0;
      k_q         <= '0;
      j_q         <= '0;
      for (int e = 0; e < N; e++) begin
        value_q[e] <= '0;
        index_q[e] <= '0;
      end
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      p_q         <= p_d;
      k_q         <= k_d;
      j_q         <= j_d;
      value_q     <= value_d;
      index_q     <= index_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/bitonic_sort_sequencer.md
BITONIC_SORT_SEQUENCER -- requirements
Module: bitonic_sort_sequencer

Interface
REQ-001 Parameters SHALL be one per line as name, default, meaning:
- LOG_N, 3, log2 of entries per sort block (N = 2^LOG_N).
- NETWORK_WIDTH, shared parameters header, value width.
- INDEX_WIDTH, shared parameters header, index width; SHALL be >= LOG_N.
REQ-002 Ports SHALL be one per line as name, direction, width, meaning:
- clk  in  1  sole clock.
- reset  in  1  active-low synchronous reset.
- in_valid  in  1  load word offered.
- in_ready  out  1  block accepts load word.
- in_data  in  NETWORK_WIDTH  load value.
- out_valid  out  1  sorted word offered.
- out_ready  in  1  consumer accepts sorted word.
- out_data  out  NETWORK_WIDTH  sorted value.
- out_index  out  INDEX_WIDTH  arrival position (0..N-1) of out_data.
- busy  out  1  high in SORT and DRAIN.
- done  out  1  one-cycle pulse on final drain handshake.
REQ-003 Clocking: one clock; reset is synchronous and active-low.

Function
REQ-004 Internal bank SHALL hold N entries {value, index}; one compare-exchange per clock, no external comparator instance.
REQ-005 FSM states SHALL be LOAD, SORT, DRAIN; LOAD->SORT on Nth accept, SORT->DRAIN after final pair, DRAIN->LOAD on Nth drain handshake.
REQ-006 LOAD: in_ready=1; accept on in_valid&in_ready; word k (0-based) written to entry k as {in_data, k}.
REQ-007 in_ready SHALL be 0 in SORT and DRAIN; in_valid there SHALL be ignored with no state change.
REQ-008 SORT order: k_log 1..LOG_N ascending; per k_log, j_log k_log-1 down to 0; per pass, pair counter p 0..N/2-1.
REQ-009 Pair: i = p with a 0 inserted at bit j_log; l = i | (1<<j_log).
REQ-010 If bit k_log of i is 0 (descending): swap entries i,l iff value[i] < value[l]; else (ascending): swap iff value[i] > value[l]; equal values never swap.
REQ-011 Swap SHALL exchange value and index together; write at the clock edge ending the pair's cycle.
REQ-012 SORT SHALL last exactly N/2 * LOG_N*(LOG_N+1)/2 cycles (24 for LOG_N=3); no stalls.
REQ-013 Final result: entry 0 holds largest value, entry N-1 smallest (non-increasing).
REQ-014 DRAIN: out_valid=1, out_data/out_index = entry[rd_ptr], rd_ptr from 0; advance only on out_valid&out_ready.
REQ-015 With out_ready=0, out_data/out_index SHALL hold stable.
REQ-016 done SHALL pulse in the cycle after the Nth drain handshake, coincident with in_ready=1 (LOAD re-entered).
REQ-017 Outside DRAIN, out_valid=0, out_data=0, out_index=0.
REQ-018 Counters SHALL wrap to 0 on state exit; no partial-block sort; fewer than N loads SHALL wait indefinitely in LOAD.

Reset
REQ-019 With reset=0 at a clock edge: state=LOAD, all counters=0, bank cleared to 0, in_ready=1, out_valid=0, out_data=0, out_index=0, busy=0, done=0.
REQ-020 Reset SHALL take priority over all handshakes; reset during SORT or DRAIN SHALL discard the block with no done pulse.

Verification (LOG_N=3)
REQ-021 Load 1,2,...,8 -> after 24 SORT cycles, out_data 8,7,...,1 with out_index 7,6,...,0; done pulses once.
REQ-022 Load eight 5s -> out_data all 5, out_index 0,1,...,7 (no swaps).
REQ-023 Load 3,0,7,7,1,9,2,4 -> out_data 9,7,7,4,3,2,1,0; indices 5,{2,3},7,0,6,4,1.
REQ-024 out_ready low 3 cycles during 4th output word -> word held stable, no loss or duplication, total 8 handshakes.
REQ-025 reset=0 during SORT cycle 10 -> next cycle in_ready=1, busy=0, out_valid=0; fresh load of 8..1 drains 8..1 with indices 0..7.
REQ-026 in_valid held 1 through SORT/DRAIN with changing in_data -> no effect on output; next block loads from first cycle after done.
